// File: rtl/mem_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_write_buffer                                                           |
// | Circular FIFO of ALU memory writes, drained to memory over valid/ready.    |
// | Optional MEM_WRITE_BUFFER_COALESCE_EN: merge a write into the newest entry |
// | when the addresses match.                                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_write_buffer #(
  parameter  int mem_addr_width = 16,
  parameter  int depth          = 4,
  localparam int REG_WIDTH      = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         w_valid_i,
  input  logic [mem_addr_width-1:0]    w_addr_i,
  input  logic [REG_WIDTH-1:0]         w_write_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(depth+1)-1:0]   count_o,
  output logic                         overflow_o,
  output logic                         m_valid_o,
  output logic [mem_addr_width-1:0]    m_addr_o,
  output logic [REG_WIDTH-1:0]         m_data_o,
  input  logic                         m_ready_i
);

  localparam int c_ptr_w = $clog2(depth);
  localparam int c_cnt_w = $clog2(depth+1);

  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(depth);

  logic [mem_addr_width-1:0] r_addr_mem [depth];
  logic [REG_WIDTH-1:0]      r_data_mem [depth];

  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic               r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_coalesce;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && m_ready_i;

`ifdef MEM_WRITE_BUFFER_COALESCE_EN
  logic [c_ptr_w-1:0] w_newest;

  assign w_newest = r_tail - c_ptr_one;

  // The newest entry is also the head when count is 1; if it leaves this
  // cycle the write must become a fresh entry instead of being lost.
  assign w_coalesce = w_valid_i && !w_empty
                   && (r_addr_mem[w_newest] == w_addr_i)
                   && !((r_count == c_cnt_one) && w_pop);
`else
  assign w_coalesce = 1'b0;
`endif

  // Full is judged on registered state only, so a same-cycle pop never frees a slot.
  assign w_push = w_valid_i && !w_full && !w_coalesce;
  assign w_drop = w_valid_i &&  w_full && !w_coalesce;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr_mem[r_tail] <= w_addr_i;
      r_data_mem[r_tail] <= w_write_i;
    end
`ifdef MEM_WRITE_BUFFER_COALESCE_EN
    if (w_coalesce) begin
      r_data_mem[w_newest] <= w_write_i;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_ptr_one;
      end
      if (w_pop) begin
        r_head <= r_head + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign count_o    = r_count;
  assign overflow_o = r_overflow;
  assign m_valid_o  = !w_empty;
  assign m_addr_o   = r_addr_mem[r_head];
  assign m_data_o   = r_data_mem[r_head];

endmodule
`default_nettype wire

// File: tb/tb_mem_write_buffer.sv
`default_nettype none
// Self-checking bench for mem_write_buffer: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_mem_write_buffer;

  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic          w_valid_i = 1'b0;
  logic [AW-1:0] w_addr_i = '0;
  logic [31:0]   w_write_i = '0;
  logic          m_ready_i = 1'b0;
  logic          full_o, empty_o, overflow_o, m_valid_o;
  logic [CW-1:0] count_o;
  logic [AW-1:0] m_addr_o;
  logic [31:0]   m_data_o;

  int total = 0;
  int bad   = 0;

  // Model: queue of {addr, data}, front is the entry memory sees next.
  logic [AW+31:0] model_q [$];
  bit             model_ovf;

  always #5 clk_i = ~clk_i;

  mem_write_buffer #(.mem_addr_width(AW), .depth(DEPTH)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .w_valid_i  (w_valid_i),
    .w_addr_i   (w_addr_i),
    .w_write_i  (w_write_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .m_valid_o  (m_valid_o),
    .m_addr_o   (m_addr_o),
    .m_data_o   (m_data_o),
    .m_ready_i  (m_ready_i)
  );

  // Apply the buffer rules to the model for the current inputs, then clock.
  task automatic step();
    bit pop, coal, is_full;
    logic [AW+31:0] e;
    pop     = (model_q.size() > 0) && m_ready_i;
    is_full = (model_q.size() == DEPTH);
    coal    = 1'b0;
`ifdef MEM_WRITE_BUFFER_COALESCE_EN
    if (w_valid_i && model_q.size() > 0)
      coal = (model_q[model_q.size()-1][AW+31:32] == w_addr_i) && !(model_q.size() == 1 && pop);
`endif
    if (coal) begin
      e = model_q[model_q.size()-1];
      e[31:0] = w_write_i;
      model_q[model_q.size()-1] = e;
    end else if (w_valid_i && is_full) begin
      model_ovf = 1'b1;
    end
    if (pop) void'(model_q.pop_front());
    if (w_valid_i && !is_full && !coal) model_q.push_back({w_addr_i, w_write_i});
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_ni  = 1'b0;
    w_valid_i = 1'b0;
    m_ready_i = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (empty_o !== 1'b1)    begin bad++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    total++; if (full_o !== 1'b0)     begin bad++; $display("FAIL reset_full: got %b want 0", full_o); end
    total++; if (m_valid_o !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid_o); end
    total++; if (count_o !== 3'd0)    begin bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
  endtask

  task automatic test_basic_write();
    do_reset();
    w_valid_i = 1'b1; w_addr_i = 16'h0010; w_write_i = 32'hDEADBEEF; m_ready_i = 1'b1;
    step();
    w_valid_i = 1'b0;
    total++;
    if (m_valid_o !== 1'b1 || m_addr_o !== 16'h0010 || m_data_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL basic_head: got v=%b a=%h d=%h want v=1 a=0010 d=deadbeef", m_valid_o, m_addr_o, m_data_o);
    end
    step();
    total++;
    if (m_valid_o !== 1'b0 || empty_o !== 1'b1) begin
      bad++; $display("FAIL basic_drained: got v=%b e=%b want v=0 e=1", m_valid_o, empty_o);
    end
  endtask

  task automatic test_fill_overflow_drain();
    logic [31:0] exp_data [4];
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_data[i] = $urandom;
      w_valid_i = 1'b1; w_addr_i = AW'(i + 1); w_write_i = exp_data[i];
      step();
    end
    w_valid_i = 1'b0;
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", count_o); end
    total++; if (full_o !== 1'b1)  begin bad++; $display("FAIL fill_full: got %b want 1", full_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fill_ovf: got %b want 0", overflow_o); end
    w_valid_i = 1'b1; w_addr_i = 16'h0005; w_write_i = $urandom;
    step();
    w_valid_i = 1'b0;
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow_o); end
    total++; if (count_o !== 3'd4)    begin bad++; $display("FAIL ovf_count: got %0d want 4", count_o); end
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (m_valid_o !== 1'b1 || m_addr_o !== AW'(i + 1) || m_data_o !== exp_data[i]) begin
        bad++; $display("FAIL drain_%0d: got v=%b a=%h d=%h want v=1 a=%h d=%h",
                        i, m_valid_o, m_addr_o, m_data_o, AW'(i + 1), exp_data[i]);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (m_valid_o !== 1'b0 || empty_o !== 1'b1) begin
        bad++; $display("FAIL dropped_absent: got v=%b a=%h want v=0", m_valid_o, m_addr_o);
      end
      step();
    end
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
  endtask

  task automatic test_hold_push_pop();
    logic [AW+31:0] head;
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_valid_i = 1'b1; w_addr_i = AW'(16'h0100 + i); w_write_i = $urandom;
      step();
    end
    w_valid_i = 1'b0;
    head = model_q[0];
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (m_valid_o !== 1'b1 || {m_addr_o, m_data_o} !== head) begin
        bad++; $display("FAIL hold_%0d: got v=%b %h want %h", i, m_valid_o, {m_addr_o, m_data_o}, head);
      end
    end
    m_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      w_valid_i = 1'b1; w_addr_i = AW'(16'h0200 + k); w_write_i = $urandom;
      total++;
      if (count_o !== 3'd2 || {m_addr_o, m_data_o} !== model_q[0]) begin
        bad++; $display("FAIL pushpop_%0d: got c=%0d %h want c=2 %h", k, count_o, {m_addr_o, m_data_o}, model_q[0]);
      end
      step();
    end
    w_valid_i = 1'b0;
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL pushpop_end: got %0d want 2", count_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_valid_i = 1'b1; w_addr_i = AW'(16'h0030 + i); w_write_i = $urandom;
      step();
    end
    w_valid_i = 1'b0; m_ready_i = 1'b1;
    step();
    total++;
    if (count_o !== 3'd3 || overflow_o !== 1'b1) begin
      bad++; $display("FAIL arst_pre: got c=%0d o=%b want c=3 o=1", count_o, overflow_o);
    end
    #2 reset_ni = 1'b0;
    #1;
    model_q.delete(); model_ovf = 1'b0;
    total++;
    if (m_valid_o !== 1'b0 || count_o !== 3'd0 || overflow_o !== 1'b0 || empty_o !== 1'b1) begin
      bad++; $display("FAIL arst_now: got v=%b c=%0d o=%b e=%b want v=0 c=0 o=0 e=1",
                      m_valid_o, count_o, overflow_o, empty_o);
    end
    @(posedge clk_i); #1 reset_ni = 1'b1;
    m_ready_i = 1'b0;
  endtask

  task automatic test_coalesce();
    logic [AW-1:0] wa [4];
    logic [31:0]   wd [4];
    logic [AW-1:0] ea [4];
    logic [31:0]   ed [4];
    int n;
    wa = '{16'h8, 16'h9, 16'h9, 16'h9};
    wd = '{32'd1, 32'd2, 32'd3, 32'd4};
`ifdef MEM_WRITE_BUFFER_COALESCE_EN
    n = 2; ea = '{16'h8, 16'h9, 16'h0, 16'h0}; ed = '{32'd1, 32'd4, 32'd0, 32'd0};
`else
    n = 4; ea = wa; ed = wd;
`endif
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_valid_i = 1'b1; w_addr_i = wa[i]; w_write_i = wd[i];
      step();
    end
    w_valid_i = 1'b0;
    total++; if (count_o !== CW'(n)) begin bad++; $display("FAIL coal_count: got %0d want %0d", count_o, n); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL coal_ovf: got %b want 0", overflow_o); end
    m_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      total++;
      if (m_valid_o !== 1'b1 || m_addr_o !== ea[i] || m_data_o !== ed[i]) begin
        bad++; $display("FAIL coal_drain_%0d: got v=%b a=%h d=%h want a=%h d=%h",
                        i, m_valid_o, m_addr_o, m_data_o, ea[i], ed[i]);
      end
      step();
    end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL coal_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_random();
    int ready_pct;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ready_pct = (c < 200) ? 30 : (c < 400) ? 80 : 55;
      w_valid_i = ($urandom_range(0, 99) < 60);
      m_ready_i = ($urandom_range(0, 99) < ready_pct);
      w_addr_i  = AW'($urandom_range(0, 3));
      w_write_i = $urandom;
      total++;
      if (count_o !== CW'(model_q.size()) || empty_o !== (model_q.size() == 0) ||
          full_o !== (model_q.size() == DEPTH) || m_valid_o !== (model_q.size() != 0) ||
          overflow_o !== model_ovf ||
          (model_q.size() != 0 && {m_addr_o, m_data_o} !== model_q[0])) begin
        bad++;
        $display("FAIL random_%0d: got c=%0d f=%b e=%b v=%b o=%b head=%h want c=%0d o=%b head=%h",
                 c, count_o, full_o, empty_o, m_valid_o, overflow_o, {m_addr_o, m_data_o},
                 model_q.size(), model_ovf, (model_q.size() != 0) ? model_q[0] : '0);
      end
      step();
    end
    w_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_fill_overflow_drain();
    test_hold_push_pop();
    test_async_reset();
    test_coalesce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
